mlaccel_qpi_slave: RTL

- QPI slave front end inside mlaccel_top. It receives the host nibble stream (qpi_csb, qpi_clk, qpi_io0..3) and turns it into a byte stream for the command decoder (0x20 status, 0x21/0x22 buffer write/read, 0x23/0x24 copy, 0x25 run).
- It serialises decoder reply bytes back onto the pads.
- Pad tristating is done in mlaccel_top. This block only provides io_do and io_oe.
- All QPI inputs are asynchronous. Everything runs on `clock`.

---
 rtl/mlaccel_qpi_slave.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mlaccel_qpi_slave.sv
// mlaccel_qpi_slave: QPI slave front end. Resynchronises the host nibble bus
// onto `clock`, assembles command/data bytes for the decoder and shifts reply
// bytes back out through io_do/io_oe (tristate buffers live in mlaccel_top).
// Build option: define MLACCEL_QPI_BYTECNT_EN to enable the xfer_count byte
// counter; without it xfer_count is tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | CSB high, pads released, waiting for a CSB fall
// RX_HI    | waiting for high nibble; with tx_mode up (and not the command
//          | byte) the rise is instead the first turnaround nibble
// RX_LO    | waiting for low nibble; byte is presented on the following cycle
// DUMMY_LO | second turnaround nibble; its rise loads and drives the TX byte
// TX_HI    | high nibble on pads; its rise switches to the low nibble
// TX_LO    | low nibble on pads; its rise ends the byte
module mlaccel_qpi_slave #(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [7:0] UNDERFLOW_BYTE = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        qpi_csb,
    input  logic        qpi_clk,
    input  logic [3:0]  io_di,
    output logic [3:0]  io_do,
    output logic        io_oe,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_first,
    output logic        rx_end,
    input  logic        tx_mode,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        qpi_err,
    input  logic        rx_ready,
    output logic [15:0] xfer_count
);

    typedef enum logic [2:0] {IDLE, RX_HI, RX_LO, DUMMY_LO, TX_HI, TX_LO} state_t;

    logic [SYNC_STAGES-1:0] csb_sync;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [3:0]             io_sync [SYNC_STAGES];
    logic                   csb_last;
    logic                   clk_last;
    logic                   csb_s;
    logic                   clk_s;
    logic [3:0]             io_s;
    logic                   csb_fall;
    logic                   csb_rise;
    logic                   clk_rise;

    state_t     state, state_next;
    logic       first_flag, first_next;
    logic [3:0] hi_nib, hi_next;
    logic [3:0] tx_lo, tx_lo_next;
    logic [3:0] do_next;
    logic       oe_next;
    logic       rx_valid_next;
    logic [7:0] rx_data_next;
    logic       rx_first_next;
    logic       rx_end_next;
    logic       tx_ready_c;
    logic [7:0] tx_byte;

    // Synchronisers. The CSB chain resets low so that a CSB already low when
    // reset is released is not mistaken for a fresh fall; a new transaction
    // needs CSB to go high and fall again.
    always_ff @(posedge clock) begin
        if (reset) begin
            csb_sync <= '0;
            clk_sync <= '0;
            io_sync  <= '{default: 4'h0};
            csb_last <= 1'b0;
            clk_last <= 1'b0;
        end else begin
            csb_sync <= {csb_sync[SYNC_STAGES-2:0], qpi_csb};
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], qpi_clk};
            io_sync[0] <= io_di;
            for (int i = 1; i < SYNC_STAGES; i++) io_sync[i] <= io_sync[i-1];
            csb_last <= csb_sync[SYNC_STAGES-1];
            clk_last <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign csb_s    = csb_sync[SYNC_STAGES-1];
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign io_s     = io_sync[SYNC_STAGES-1];
    assign csb_fall = csb_last & ~csb_s;
    assign csb_rise = ~csb_last & csb_s;
    assign clk_rise = ~clk_last & clk_s;
    assign tx_byte  = tx_valid ? tx_data : UNDERFLOW_BYTE;
    assign tx_ready = tx_ready_c & ~reset;

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            first_flag <= 1'b0;
            hi_nib     <= 4'h0;
            tx_lo      <= 4'h0;
            io_do      <= 4'h0;
            io_oe      <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= 8'h00;
            rx_first   <= 1'b0;
            rx_end     <= 1'b0;
            qpi_err    <= 1'b0;
        end else begin
            state      <= state_next;
            first_flag <= first_next;
            hi_nib     <= hi_next;
            tx_lo      <= tx_lo_next;
            io_do      <= do_next;
            io_oe      <= oe_next;
            rx_valid   <= rx_valid_next;
            rx_data    <= rx_data_next;
            rx_first   <= rx_first_next;
            rx_end     <= rx_end_next;
            if (rx_valid && !rx_ready) qpi_err <= 1'b1;
        end
    end

    // Next-state and output decode; a CSB rise overrides any clk edge.
    always_comb begin
        state_next    = state;
        first_next    = first_flag;
        hi_next       = hi_nib;
        tx_lo_next    = tx_lo;
        do_next       = io_do;
        oe_next       = io_oe;
        rx_valid_next = 1'b0;
        rx_data_next  = rx_data;
        rx_first_next = 1'b0;
        rx_end_next   = 1'b0;
        tx_ready_c    = 1'b0;
        if (state != IDLE && csb_rise) begin
            state_next  = IDLE;
            oe_next     = 1'b0;
            do_next     = 4'h0;
            rx_end_next = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    oe_next = 1'b0;
                    if (csb_fall) begin
                        state_next = RX_HI;
                        first_next = 1'b1;
                    end
                end
                RX_HI: if (clk_rise) begin
                    if (tx_mode && !first_flag) begin
                        state_next = DUMMY_LO;
                    end else begin
                        hi_next    = io_s;
                        state_next = RX_LO;
                    end
                end
                RX_LO: if (clk_rise) begin
                    rx_data_next  = {hi_nib, io_s};
                    rx_valid_next = 1'b1;
                    rx_first_next = first_flag;
                    first_next    = 1'b0;
                    state_next    = RX_HI;
                end
                DUMMY_LO: if (clk_rise) begin
                    tx_ready_c = 1'b1;
                    do_next    = tx_byte[7:4];
                    tx_lo_next = tx_byte[3:0];
                    oe_next    = 1'b1;
                    state_next = TX_HI;
                end
                TX_HI: if (clk_rise) begin
                    do_next    = tx_lo;
                    state_next = TX_LO;
                end
                TX_LO: if (clk_rise) begin
                    if (tx_mode) begin
                        tx_ready_c = 1'b1;
                        do_next    = tx_byte[7:4];
                        tx_lo_next = tx_byte[3:0];
                        state_next = TX_HI;
                    end else begin
                        oe_next    = 1'b0;
                        do_next    = 4'h0;
                        state_next = RX_HI;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef MLACCEL_QPI_BYTECNT_EN
    logic [15:0] byte_cnt;
    logic        byte_done;

    assign byte_done = clk_rise && !csb_rise && (state == RX_LO || state == TX_LO);

    // Bytes in the current transaction; cleared at CSB fall, saturating.
    always_ff @(posedge clock) begin
        if (reset) begin
            byte_cnt <= 16'h0000;
        end else if (state == IDLE && csb_fall) begin
            byte_cnt <= 16'h0000;
        end else if (byte_done && byte_cnt != 16'hFFFF) begin
            byte_cnt <= byte_cnt + 16'h0001;
        end
    end

    assign xfer_count = byte_cnt;
`else
    assign xfer_count = 16'h0000;
`endif

endmodule
